amoa_err_monitor: RTL
=====================

# amoa_err_monitor

Result-side checker for the approximate multi-operand adder (8 × 8-bit operands, 11-bit `summ`). It taps the same operand bus that feeds the adder and computes the exact sum internally. It delays that sum to line up with the adder's pipelined `summ`, then accumulates error statistics over a programmable window of valid samples. It sits beside the adder in benches and on-chip characterisation wrappers. It is the reader that consumes what the adder produces.

## Interface
Parameters:
- `LAT`, default 2: cycles from the operand bus `x0..x7` to the matching `summ`. Legal range is 1..8.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse that arms a measurement window.
- `win_len`  in  16  number of samples to measure. It is sampled on an accepted `start`.
- `in_vld`  in  1  operands on `x0..x7` are a valid sample this cycle.
- `x0`..`x7`  in  8 each  operand bus, the same bus the adder sees.
- `summ`  in  11  adder output.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `smp_cnt`  out  16  samples compared in the current or last window.
- `err_cnt`  out  16  samples with a nonzero error.
- `abs_err_sum`  out  27  sum of |error|.
- `max_abs_err`  out  11  largest |error|. Present only with `AMOA_ERRMON_MAX_EN`; otherwise tied to 0.

## Operation
- Exact sum: `ex = x0+…+x7`, zero-extended to 11 bits, giving a maximum of 2040.
- Delay line: `LAT` stages, each carrying `ex` and a tag. The tag is `in_vld & (state==RUN)`.
- Compare at the line output (the tag is set):
  - `err = ex_d - summ`, computed as 12-bit signed.
  - `abs = |err|`, 11 bits, maximum 2040.
  - `smp_cnt += 1`.
  - `err_cnt += (abs != 0)`.
  - `abs_err_sum += abs`. This cannot overflow: 65535 × 2040 < 2^27.
  - `max_abs_err = max(max_abs_err, abs)`.
- FSM states are IDLE, RUN and DONE.
  - IDLE → RUN when `start` is high and `win_len != 0`. On that edge:
    - all statistics clear to 0;
    - `win_len` is latched;
    - delay-line tags clear.
  - `start` with `win_len == 0` is ignored, and the block stays in its current state.
  - RUN → DONE on the edge where a tagged compare makes `smp_cnt` equal the latched length. Tagged samples still in flight are then discarded and not counted.
  - DONE → RUN on `start` with `win_len != 0`. This clears statistics exactly as from IDLE.
  - DONE holds its statistics until that `start` or reset.
  - `start` during RUN is ignored.
- `in_vld` gaps are allowed. Untagged samples never update statistics.
- Samples issued in IDLE or DONE are untagged, even if they reach the compare point during RUN.

## Timing
- Reset values:
  - state is IDLE;
  - `busy`, `done`, `smp_cnt`, `err_cnt`, `abs_err_sum` and `max_abs_err` are all 0;
  - all delay-line contents and tags are 0.
- Reset is effective immediately and mid-window. The partial window is discarded.
- `busy` rises the cycle after the accepted `start`. The first taggable sample is the one with `in_vld` high on that same next cycle.
- A sample with `in_vld` high at edge k is compared against `summ` at edge k+`LAT`.
- Statistics are registered. They are visible the cycle after the compare edge.
- With continuous `in_vld` and window length N, `done` rises `N+LAT` cycles after `busy` rises. On that same edge `busy` falls.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Configuration
- `AMOA_ERRMON_MAX_EN` defined: the `max_abs_err` register and comparator are built, and the port reports the running maximum.
- Not defined: no register is built, and `max_abs_err` is constant 0. All other behaviour is identical.

## Test plan
- The bench stub drives `summ` equal to the delayed exact sum, with `LAT=2`, `win_len=4` and all `x=1`. Required result: `done`, `smp_cnt=4`, `err_cnt=0`, `abs_err_sum=0`, `max_abs_err=0`.
- The stub drives `summ = exact-3` every sample, `win_len=10`. Required result: `err_cnt=10`, `abs_err_sum=30`, `max_abs_err=3` (0 without the macro).
- Exact sum 8 (all `x=1`) with `summ=12` for one sample and exact elsewhere, `win_len=5`. Required result: `err_cnt=1`, `abs_err_sum=4`, `max_abs_err=4`.
- All `x=255` with `summ=0`, `win_len=2`. Required result: `abs_err_sum=4080`, `max_abs_err=2040`.
- `in_vld` toggles 1,0,1,0… with `win_len=3` and error 1 per sample. Required result: `smp_cnt=3` and `abs_err_sum=3`. `done` asserts on the edge of the third valid sample's compare. A `start` with `win_len=0`, issued while in DONE, leaves the statistics unchanged.
- `rst_n` is pulsed low mid-RUN after 2 samples. Required result: all outputs are 0 immediately, and the FSM is in IDLE. A new `start` with `win_len=2` then completes with `smp_cnt=2`.

Source files
------------

// File: rtl/amoa_err_monitor.sv
// Error monitor for the approximate 8-operand adder: delays the exact operand sum by LAT cycles,
// compares it with summ and accumulates windowed error statistics. Optional: AMOA_ERRMON_MAX_EN.
module amoa_err_monitor #(
  parameter int unsigned LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_win_len,
  input  logic        i_in_vld,
  input  logic [7:0]  i_x0,
  input  logic [7:0]  i_x1,
  input  logic [7:0]  i_x2,
  input  logic [7:0]  i_x3,
  input  logic [7:0]  i_x4,
  input  logic [7:0]  i_x5,
  input  logic [7:0]  i_x6,
  input  logic [7:0]  i_x7,
  input  logic [10:0] i_summ,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_smp_cnt,
  output logic [15:0] o_err_cnt,
  output logic [26:0] o_abs_err_sum,
  output logic [10:0] o_max_abs_err
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2} state_e;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [15:0]    r_win_len;
  logic [15:0]    r_smp_cnt;
  logic [15:0]    r_err_cnt;
  logic [26:0]    r_abs_err_sum;
  logic [10:0]    r_ex_pipe [LAT];
  logic [LAT-1:0] r_tag_pipe;

  logic [10:0] w_ex;
  logic [11:0] w_err;
  logic [11:0] w_err_neg;
  logic [10:0] w_abs;
  logic [15:0] w_smp_nxt;
  logic        w_start_ok;
  logic        w_tag_in;
  logic        w_cmp;
  logic        w_last;

  assign w_ex = {3'b0, i_x0} + {3'b0, i_x1} + {3'b0, i_x2} + {3'b0, i_x3}
              + {3'b0, i_x4} + {3'b0, i_x5} + {3'b0, i_x6} + {3'b0, i_x7};

  // start is only honoured outside RUN and with a nonzero window length
  assign w_start_ok = i_start && (i_win_len != 16'd0) && (r_state != StRun);
  assign w_tag_in   = i_in_vld && (r_state == StRun);
  assign w_cmp      = r_tag_pipe[LAT-1] && (r_state == StRun);
  assign w_smp_nxt  = r_smp_cnt + 16'd1;
  assign w_last     = w_cmp && (w_smp_nxt == r_win_len);

  assign w_err     = {1'b0, r_ex_pipe[LAT-1]} - {1'b0, i_summ};
  assign w_err_neg = ~w_err + 12'd1;
  assign w_abs     = w_err[11] ? w_err_neg[10:0] : w_err[10:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start_ok) w_state_nxt = StRun;
      StRun:          if (w_last) w_state_nxt = StDone;
      default:        w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_busy        = (r_state == StRun);
    o_done        = (r_state == StDone);
    o_smp_cnt     = r_smp_cnt;
    o_err_cnt     = r_err_cnt;
    o_abs_err_sum = r_abs_err_sum;
  end

  // Tags are flushed on window arm and on window end so in-flight samples never count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LAT; i++) r_ex_pipe[i] <= '0;
      r_tag_pipe <= '0;
    end else begin
      r_ex_pipe[0] <= w_ex;
      for (int unsigned i = 1; i < LAT; i++) r_ex_pipe[i] <= r_ex_pipe[i-1];
      if (w_start_ok || w_last) begin
        r_tag_pipe <= '0;
      end else begin
        r_tag_pipe[0] <= w_tag_in;
        for (int unsigned i = 1; i < LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_len     <= '0;
      r_smp_cnt     <= '0;
      r_err_cnt     <= '0;
      r_abs_err_sum <= '0;
    end else if (w_start_ok) begin
      r_win_len     <= i_win_len;
      r_smp_cnt     <= '0;
      r_err_cnt     <= '0;
      r_abs_err_sum <= '0;
    end else if (w_cmp) begin
      r_smp_cnt     <= w_smp_nxt;
      r_err_cnt     <= r_err_cnt + {15'd0, (w_abs != 11'd0)};
      r_abs_err_sum <= r_abs_err_sum + {16'd0, w_abs};
    end
  end

`ifdef AMOA_ERRMON_MAX_EN
  logic [10:0] r_max_abs_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max_abs_err <= '0;
    end else if (w_start_ok) begin
      r_max_abs_err <= '0;
    end else if (w_cmp && (w_abs > r_max_abs_err)) begin
      r_max_abs_err <= w_abs;
    end
  end

  assign o_max_abs_err = r_max_abs_err;
`else
  assign o_max_abs_err = '0;
`endif

endmodule
